// File: rtl/controle_multiciclo_if.sv
// Controller <-> datapath bundle: fetch/memory handshake, ALU flag, state code and strobes.
// master = multicycle controller, slave = datapath / memory side.
interface controle_multiciclo_if;
    logic [31:0] instrucao;
    logic        mem_pronto;
    logic        zero;
    logic [3:0]  estado;
    logic        pcsrc;
    logic [11:0] immediate;
    logic        negativo;
    logic        irwrite;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic        memtoreg;
    logic [1:0]  aluop;
    logic        erro;

    modport master (
        input  instrucao, mem_pronto, zero,
        output estado, pcsrc, immediate, negativo, irwrite, regwrite,
               memread, memwrite, alusrc, memtoreg, aluop, erro
    );

    modport slave (
        output instrucao, mem_pronto, zero,
        input  estado, pcsrc, immediate, negativo, irwrite, regwrite,
               memread, memwrite, alusrc, memtoreg, aluop, erro
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle RV32 subset controller (R add/sub/or/and, addi, lw, sw, beq[/bne]).
// Define CONTROLE_BNE_EN to accept bne (branch funct3 001); otherwise it is illegal.
module controle_multiciclo (
    input  logic                  clk,
    input  logic                  rst,
    controle_multiciclo_if.master bus
);
`ifdef CONTROLE_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    localparam logic [3:0] BUSCA       = 4'b0000;
    localparam logic [3:0] DECODIFICA  = 4'b0001;
    localparam logic [3:0] EXEC_R      = 4'b0010;
    localparam logic [3:0] EXEC_I      = 4'b0011;
    localparam logic [3:0] CALC_END    = 4'b0100;
    localparam logic [3:0] MEM_LE      = 4'b0101;
    localparam logic [3:0] MEM_ESCREVE = 4'b0110;
    localparam logic [3:0] ESCREVE_REG = 4'b0111;
    localparam logic [3:0] ATUALIZA_PC = 4'b1000;
    localparam logic [3:0] DESVIO      = 4'b1001;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic [3:0]  estado_q, estado_d;
    logic [31:0] instr_q, instr_d;
    logic        pcsrc_q, pcsrc_d;
    logic [11:0] immediate_q, immediate_d;
    logic        negativo_q, negativo_d;
    logic        erro_q, erro_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [12:0] off;
    logic [12:0] off_mag;
    logic        off_min;
    logic        leg_r, leg_i, leg_ld, leg_st, leg_br;
    logic        unused_ok;

    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign funct7  = instr_q[31:25];
    assign off     = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign off_mag = off[12] ? (13'd0 - off) : off;
    // -4096 has no 12-bit magnitude, so such a branch is rejected as illegal
    assign off_min = (off == 13'h1000);

    assign leg_r  = (opcode == OP_R) &&
                    (((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                     (((funct3 == 3'b110) || (funct3 == 3'b111)) && (funct7 == 7'b0000000)));
    assign leg_i  = (opcode == OP_I)  && (funct3 == 3'b000);
    assign leg_ld = (opcode == OP_LD) && (funct3 == 3'b010);
    assign leg_st = (opcode == OP_ST) && (funct3 == 3'b010);
    assign leg_br = (opcode == OP_BR) && !off_min &&
                    ((funct3 == 3'b000) || (BNE_EN && (funct3 == 3'b001)));

    assign unused_ok = ^{instr_q[24:15], off_mag[12]};

    always_comb begin
        estado_d    = estado_q;
        instr_d     = instr_q;
        pcsrc_d     = pcsrc_q;
        immediate_d = immediate_q;
        negativo_d  = negativo_q;
        erro_d      = erro_q;
        case (estado_q)
            BUSCA: begin
                if (bus.mem_pronto) begin
                    instr_d  = bus.instrucao;
                    estado_d = DECODIFICA;
                end
            end
            DECODIFICA: begin
                immediate_d = off_mag[11:0];
                negativo_d  = off[12];
                if (leg_r)                 estado_d = EXEC_R;
                else if (leg_i)            estado_d = EXEC_I;
                else if (leg_ld || leg_st) estado_d = CALC_END;
                else if (leg_br)           estado_d = DESVIO;
                else begin
                    estado_d = ATUALIZA_PC;
                    pcsrc_d  = 1'b0;
                    erro_d   = 1'b1;
                end
            end
            EXEC_R, EXEC_I: estado_d = ESCREVE_REG;
            CALC_END:       estado_d = (opcode == OP_LD) ? MEM_LE : MEM_ESCREVE;
            MEM_LE:         if (bus.mem_pronto) estado_d = ESCREVE_REG;
            MEM_ESCREVE:    if (bus.mem_pronto) estado_d = ATUALIZA_PC;
            ESCREVE_REG:    estado_d = ATUALIZA_PC;
            DESVIO: begin
                // only beq (000) and, when enabled, bne (001) can reach this state
                pcsrc_d  = (funct3 == 3'b001) ? !bus.zero : bus.zero;
                estado_d = ATUALIZA_PC;
            end
            ATUALIZA_PC: begin
                pcsrc_d  = 1'b0;
                estado_d = BUSCA;
            end
            default: estado_d = BUSCA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= BUSCA;
            instr_q     <= 32'd0;
            pcsrc_q     <= 1'b0;
            immediate_q <= 12'd0;
            negativo_q  <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            instr_q     <= instr_d;
            pcsrc_q     <= pcsrc_d;
            immediate_q <= immediate_d;
            negativo_q  <= negativo_d;
            erro_q      <= erro_d;
        end
    end

    // Strobes are gated by rst so they drop the instant reset asserts
    always_comb begin
        bus.irwrite  = 1'b0;
        bus.regwrite = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.alusrc   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.aluop    = 2'b00;
        if (!rst) begin
            case (estado_q)
                BUSCA: begin
                    bus.irwrite = bus.mem_pronto;
                    bus.memread = bus.mem_pronto;
                end
                EXEC_R:           bus.aluop  = 2'b10;
                EXEC_I, CALC_END: bus.alusrc = 1'b1;
                MEM_LE:           bus.memread  = 1'b1;
                MEM_ESCREVE:      bus.memwrite = 1'b1;
                ESCREVE_REG: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = (opcode == OP_LD);
                end
                DESVIO:           bus.aluop = 2'b01;
                default: ;
            endcase
        end
    end

    assign bus.estado    = estado_q;
    assign bus.pcsrc     = pcsrc_q;
    assign bus.immediate = immediate_q;
    assign bus.negativo  = negativo_q;
    assign bus.erro      = erro_q;
endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized bench for controle_multiciclo: a per-instruction cycle script built from the
// instruction classes is replayed against the DUT and compared cycle by cycle.
module tb_controle_multiciclo;
    logic clk = 1'b0;
    logic rst = 1'b0;

    controle_multiciclo_if bus ();

    controle_multiciclo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef CONTROLE_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic        erro_m;
    logic [11:0] imm_m;
    logic        neg_m;

    // st: required state code, sv: {irwrite,regwrite,memread,memwrite,alusrc,memtoreg,aluop,pcsrc}
    typedef struct packed {
        logic [3:0] st;
        logic [8:0] sv;
        logic       mp;
        logic       z;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic logic [8:0] sv(input logic ir, input logic rw, input logic mr,
                                      input logic mw, input logic as, input logic mtr,
                                      input logic [1:0] aop, input logic pc);
        return {ir, rw, mr, mw, as, mtr, aop, pc};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [3:0] st, input logic [8:0] s, input logic mp, input logic z);
        cyc_t c;
        c.st = st;
        c.sv = s;
        c.mp = mp;
        c.z  = z;
        exp_q.push_back(c);
    endtask

    function automatic logic [8:0] act_sv();
        return {bus.irwrite, bus.regwrite, bus.memread, bus.memwrite, bus.alusrc,
                bus.memtoreg, bus.aluop, bus.pcsrc};
    endfunction

    // Reference: expand one instruction into its per-cycle expectations
    task automatic build(input logic [31:0] ins, input int w0, input int w1, input logic zv);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         off;
        bit         legal;
        logic       taken;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        off = (ins[31] ? -4096 : 0) + (ins[7] ? 2048 : 0)
              + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        case (op)
            7'h33:   legal = (f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ||
                             ((f3 == 3'd6 || f3 == 3'd7) && f7 == 7'h00);
            7'h13:   legal = (f3 == 3'd0);
            7'h03:   legal = (f3 == 3'd2);
            7'h23:   legal = (f3 == 3'd2);
            7'h63:   legal = (f3 == 3'd0 || (BNE_EN && f3 == 3'd1)) && (off != -4096);
            default: legal = 1'b0;
        endcase
        taken = (f3 == 3'd0) ? zv : !zv;
        neg_m = (off < 0);
        imm_m = 12'((off < 0) ? -off : off);

        for (int i = 0; i < w0; i++) push(4'd0, 9'd0, 1'b0, rb());
        push(4'd0, sv(1, 0, 1, 0, 0, 0, 2'b00, 0), 1'b1, rb());
        push(4'd1, 9'd0, rb(), rb());
        if (!legal) begin
            erro_m = 1'b1;
            push(4'd8, 9'd0, rb(), rb());
        end else begin
            case (op)
                7'h33: begin
                    push(4'd2, sv(0, 0, 0, 0, 0, 0, 2'b10, 0), rb(), rb());
                    push(4'd7, sv(0, 1, 0, 0, 0, 0, 2'b00, 0), rb(), rb());
                end
                7'h13: begin
                    push(4'd3, sv(0, 0, 0, 0, 1, 0, 2'b00, 0), rb(), rb());
                    push(4'd7, sv(0, 1, 0, 0, 0, 0, 2'b00, 0), rb(), rb());
                end
                7'h03: begin
                    push(4'd4, sv(0, 0, 0, 0, 1, 0, 2'b00, 0), rb(), rb());
                    for (int i = 0; i < w1; i++) push(4'd5, sv(0, 0, 1, 0, 0, 0, 2'b00, 0), 1'b0, rb());
                    push(4'd5, sv(0, 0, 1, 0, 0, 0, 2'b00, 0), 1'b1, rb());
                    push(4'd7, sv(0, 1, 0, 0, 0, 1, 2'b00, 0), rb(), rb());
                end
                7'h23: begin
                    push(4'd4, sv(0, 0, 0, 0, 1, 0, 2'b00, 0), rb(), rb());
                    for (int i = 0; i < w1; i++) push(4'd6, sv(0, 0, 0, 1, 0, 0, 2'b00, 0), 1'b0, rb());
                    push(4'd6, sv(0, 0, 0, 1, 0, 0, 2'b00, 0), 1'b1, rb());
                end
                default: begin
                    push(4'd9, sv(0, 0, 0, 0, 0, 0, 2'b01, 0), rb(), zv);
                end
            endcase
            push(4'd8, sv(0, 0, 0, 0, 0, 0, 2'b00, (op == 7'h63) ? taken : 1'b0), rb(), rb());
        end
    endtask

    // Replay up to n expected cycles (n < 0: all); starts and ends at posedge + 1
    task automatic play(input logic [31:0] ins, input int n);
        cyc_t c;
        int   k;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            c = exp_q.pop_front();
            bus.mem_pronto = c.mp;
            bus.zero       = c.z;
            bus.instrucao  = (c.st == 4'd0 && c.mp) ? ins : $urandom;
            @(negedge clk);
            checks++;
            if (bus.estado !== c.st) begin
                errors++;
                $display("FAIL estado ins=%h cyc=%0d: got %b want %b", ins, k, bus.estado, c.st);
            end
            checks++;
            if (act_sv() !== c.sv) begin
                errors++;
                $display("FAIL strobes ins=%h cyc=%0d: got %b want %b", ins, k, act_sv(), c.sv);
            end
            if (c.st == 4'd8) begin
                checks++;
                if (bus.immediate !== imm_m || bus.negativo !== neg_m) begin
                    errors++;
                    $display("FAIL offset ins=%h: got imm=%0d neg=%b want imm=%0d neg=%b",
                             ins, bus.immediate, bus.negativo, imm_m, neg_m);
                end
                checks++;
                if (bus.erro !== erro_m) begin
                    errors++;
                    $display("FAIL erro ins=%h: got %b want %b", ins, bus.erro, erro_m);
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int w0, input int w1, input logic zv);
        build(ins, w0, w1, zv);
        play(ins, -1);
        $display("instr %h w0=%0d w1=%0d zero=%b done", ins, w0, w1, zv);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus.estado !== 4'd0 || act_sv() !== 9'd0 || bus.immediate !== 12'd0 ||
            bus.negativo !== 1'b0 || bus.erro !== 1'b0) begin
            errors++;
            $display("FAIL %s: got estado=%b strobes=%b imm=%0d neg=%b erro=%b want all zero",
                     tag, bus.estado, act_sv(), bus.immediate, bus.negativo, bus.erro);
        end
    endtask

    task automatic test_reset();
        #1;
        bus.mem_pronto = 1'b1;
        bus.zero       = 1'b1;
        bus.instrucao  = $urandom;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_state");
        bus.mem_pronto = 1'b0;
        rst    = 1'b0;
        erro_m = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.estado !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_hold: got %b want 0000", bus.estado);
        end
        $display("reset test done");
    endtask

    task automatic test_add();
        run_instr(32'h002081B3, 0, 0, 1'b0);
    endtask

    task automatic test_lw_wait();
        run_instr(32'h00002083, 1, 3, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(32'hFE000CE3, 0, 0, 1'b1);
        run_instr(32'hFE000CE3, 0, 0, 1'b0);
        run_instr(32'hFE001CE3, 0, 0, 1'b1);
        run_instr(32'hFE001CE3, 0, 0, 1'b0);
        run_instr(32'h80000063, 0, 0, 1'b1);
    endtask

    task automatic test_illegal_sticky();
        run_instr(32'h0000007F, 0, 0, 1'b0);
        run_instr(32'h002081B3, 0, 0, 1'b0);
        run_instr(32'h00102023, 1, 1, 1'b0);
    endtask

    task automatic test_store_reset();
        build(32'h00102023, 0, 3, 1'b0);
        play(32'h00102023, 4);
        exp_q.delete();
        bus.mem_pronto = 1'b0;
        #2;
        checks++;
        if (bus.estado !== 4'd6 || bus.memwrite !== 1'b1) begin
            errors++;
            $display("FAIL store_wait: got estado=%b memwrite=%b want 0110/1", bus.estado, bus.memwrite);
        end
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        erro_m = 1'b0;
        bus.mem_pronto = 1'b1;
        @(negedge clk);
        check_all_zero("reset_hold");
        bus.mem_pronto = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.estado !== 4'd0 || bus.memwrite !== 1'b0 || bus.regwrite !== 1'b0) begin
                errors++;
                $display("FAIL after_reset%0d: got estado=%b memwrite=%b regwrite=%b want 0000/0/0",
                         i, bus.estado, bus.memwrite, bus.regwrite);
            end
        end
        @(posedge clk);
        #1;
        $display("store reset test done");
        run_instr(32'h00002083, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  ops [7];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h00};
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            ops[6] = ins[6:0];
            ins[6:0] = ops[$urandom_range(0, 6)];
            if (rb()) begin
                case (ins[6:0])
                    7'h33: begin
                        ins[14:12] = rb() ? 3'd0 : (rb() ? 3'd6 : 3'd7);
                        ins[31:25] = (ins[14:12] == 3'd0 && rb()) ? 7'h20 : 7'h00;
                    end
                    7'h13:        ins[14:12] = 3'd0;
                    7'h03, 7'h23: ins[14:12] = 3'd2;
                    7'h63:        ins[14:12] = {2'b00, rb()};
                    default: ;
                endcase
            end
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end
    endtask

    initial begin
        bus.instrucao  = 32'd0;
        bus.mem_pronto = 1'b0;
        bus.zero       = 1'b0;
        erro_m = 1'b0;
        imm_m  = 12'd0;
        neg_m  = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_illegal_sticky();
        test_store_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
